// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO, any DEPTH >= 2, with a registered head word,
// occupancy count and almost flags. Define PARAM_SYNC_FIFO_BYPASS_EN for zero-latency bypass.
module param_sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 8,
    parameter int AFULL_THR  = DEPTH - 1,
    parameter int AEMPTY_THR = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       IN_flush,
    input  logic [WIDTH-1:0]           IN_data,
    input  logic                       IN_valid,
    output logic                       OUT_ready,
    input  logic                       IN_ready,
    output logic                       OUT_valid,
    output logic [WIDTH-1:0]           OUT_data,
    output logic [$clog2(DEPTH+2)-1:0] OUT_count,
    output logic                       OUT_almostFull,
    output logic                       OUT_almostEmpty
);
    localparam int CW = $clog2(DEPTH + 2);
    localparam int PW = $clog2(DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    logic [WIDTH-1:0] mem [DEPTH];

    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    cnt_t             count_q, count_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic push, pop, store_push, bypass_take;
    logic mem_empty, load_slot, mem_wr, mem_rd;

    // Pointers wrap at DEPTH-1 explicitly, so DEPTH need not be a power of 2.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign OUT_ready = !IN_flush && (count_q < cnt_t'(DEPTH + 1));
    assign push      = IN_valid && OUT_ready;
    assign pop       = OUT_valid && IN_ready;

`ifdef PARAM_SYNC_FIFO_BYPASS_EN
    logic bypass;
    assign bypass      = (count_q == '0) && IN_valid && !IN_flush;
    assign bypass_take = bypass && IN_ready;
    assign OUT_valid   = valid_q || bypass;
    assign OUT_data    = bypass ? IN_data : data_q;
`else
    assign bypass_take = 1'b0;
    assign OUT_valid   = valid_q;
    assign OUT_data    = data_q;
`endif

    // A word handed straight through the bypass is consumed, never stored.
    assign store_push = push && !bypass_take;
    assign mem_empty  = (count_q == cnt_t'(valid_q));
    assign load_slot  = !valid_q || pop;
    assign mem_rd     = load_slot && !mem_empty;
    assign mem_wr     = store_push && !(load_slot && mem_empty);

    // NOTE: every variable gets its default before any branch, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        data_d   = data_q;
        if (IN_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end else begin
            if (mem_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (mem_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (load_slot) begin
                if (!mem_empty) begin
                    valid_d = 1'b1;
                    data_d  = mem[rd_ptr_q];
                end else if (store_push) begin
                    valid_d = 1'b1;
                    data_d  = IN_data;
                end else begin
                    valid_d = 1'b0;
                end
            end
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; the count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (mem_wr) mem[wr_ptr_q] <= IN_data;
    end

    assign OUT_count       = count_q;
    assign OUT_almostFull  = int'(count_q) >= AFULL_THR;
    assign OUT_almostEmpty = int'(count_q) <= AEMPTY_THR;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a DEPTH=8 and a DEPTH=5 instance share one stimulus stream,
// each compared every cycle against a queue-based reference model.
module tb_param_sync_fifo;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic         rdy8, ov8, af8, ae8;
    logic [W-1:0] od8;
    logic [3:0]   oc8;
    logic         rdy5, ov5, af5, ae5;
    logic [W-1:0] od5;
    logic [2:0]   oc5;

    logic         ordy [2];
    logic         ov   [2];
    logic         af   [2];
    logic         ae   [2];
    logic [W-1:0] od   [2];
    logic [3:0]   cnt  [2];

    logic [W-1:0] mq [2][$];
    int dep   [2] = '{8, 5};
    int afthr [2] = '{6, 4};
    int aethr [2] = '{1, 1};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    param_sync_fifo #(.WIDTH(W), .DEPTH(8), .AFULL_THR(6), .AEMPTY_THR(1)) u8 (
        .clk(clk), .rst_n(rst_n), .IN_flush(in_flush), .IN_data(in_data),
        .IN_valid(in_valid), .OUT_ready(rdy8), .IN_ready(in_ready),
        .OUT_valid(ov8), .OUT_data(od8), .OUT_count(oc8),
        .OUT_almostFull(af8), .OUT_almostEmpty(ae8)
    );

    param_sync_fifo #(.WIDTH(W), .DEPTH(5)) u5 (
        .clk(clk), .rst_n(rst_n), .IN_flush(in_flush), .IN_data(in_data),
        .IN_valid(in_valid), .OUT_ready(rdy5), .IN_ready(in_ready),
        .OUT_valid(ov5), .OUT_data(od5), .OUT_count(oc5),
        .OUT_almostFull(af5), .OUT_almostEmpty(ae5)
    );

    always_comb begin
        ordy[0] = rdy8;  ordy[1] = rdy5;
        ov[0]   = ov8;   ov[1]   = ov5;
        af[0]   = af8;   af[1]   = af5;
        ae[0]   = ae8;   ae[1]   = ae5;
        od[0]   = od8;   od[1]   = od5;
        cnt[0]  = oc8;   cnt[1]  = {1'b0, oc5};
    end

    // One clock of stimulus: drive after the falling edge, compare both instances against
    // the model before the rising edge, advance the model, end at the next falling edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        logic [1:0] exp_rdy, exp_v, byp;
        in_valid = v; in_data = d; in_ready = r; in_flush = f;
        #1;
        for (int i = 0; i < 2; i++) begin
            int sz;
            logic [W-1:0] hd;
            sz = mq[i].size();
            byp[i] = 1'b0;
`ifdef PARAM_SYNC_FIFO_BYPASS_EN
            byp[i] = (sz == 0) && v && !f;
`endif
            exp_rdy[i] = !f && (sz < dep[i] + 1);
            exp_v[i]   = (sz > 0) || byp[i];
            hd         = byp[i] ? d : ((sz > 0) ? mq[i][0] : '0);
            tests++;
            if (ov[i] !== exp_v[i]) begin
                fails++; $display("FAIL valid[d%0d] t=%0t got %b exp %b", dep[i], $time, ov[i], exp_v[i]);
            end
            if (exp_v[i]) begin
                tests++;
                if (od[i] !== hd) begin
                    fails++; $display("FAIL data[d%0d] t=%0t got %h exp %h", dep[i], $time, od[i], hd);
                end
            end
            tests++;
            if (cnt[i] !== 4'(sz)) begin
                fails++; $display("FAIL count[d%0d] t=%0t got %0d exp %0d", dep[i], $time, cnt[i], sz);
            end
            tests++;
            if (ordy[i] !== exp_rdy[i]) begin
                fails++; $display("FAIL ready[d%0d] t=%0t got %b exp %b", dep[i], $time, ordy[i], exp_rdy[i]);
            end
            tests++;
            if (af[i] !== (sz >= afthr[i])) begin
                fails++; $display("FAIL afull[d%0d] t=%0t got %b count %0d", dep[i], $time, af[i], sz);
            end
            tests++;
            if (ae[i] !== (sz <= aethr[i])) begin
                fails++; $display("FAIL aempty[d%0d] t=%0t got %b count %0d", dep[i], $time, ae[i], sz);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (f) mq[i].delete();
            else begin
                if (v && exp_rdy[i]) mq[i].push_back(d);
                if (exp_v[i] && r) void'(mq[i].pop_front());
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0; in_ready = 1'b0; in_flush = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        tests++;
        if (ov8 !== 1'b0 || ov5 !== 1'b0) begin
            fails++; $display("FAIL reset_valid got %b/%b exp 0/0", ov8, ov5);
        end
        tests++;
        if (od8 !== 8'h00 || oc8 !== 4'd0 || oc5 !== 3'd0) begin
            fails++; $display("FAIL reset_data_count got %h/%0d/%0d exp 00/0/0", od8, oc8, oc5);
        end
        tests++;
        if (rdy8 !== 1'b1 || ae8 !== 1'b1 || af8 !== 1'b0 || ae5 !== 1'b1 || af5 !== 1'b0) begin
            fails++; $display("FAIL reset_flags got rdy=%b ae=%b af=%b exp 1 1 0", rdy8, ae8, af8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mq[0].delete(); mq[1].delete();
    endtask

    task automatic test_basic_order();
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        tests++;
        if (ov8 !== 1'b1 || od8 !== 8'h11) begin
            fails++; $display("FAIL first_latency got v=%b d=%h exp v=1 d=11", ov8, od8);
        end
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        tests++;
        if (oc8 !== 4'd3) begin
            fails++; $display("FAIL basic_count got %0d exp 3", oc8);
        end
        for (int k = 0; k < 3; k++) begin
            logic [W-1:0] want;
            want = W'(8'h11 * (k + 1));
            tests++;
            if (ov8 !== 1'b1 || od8 !== want) begin
                fails++; $display("FAIL basic_order[%0d] got %h exp %h", k, od8, want);
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        tests++;
        if (oc8 !== 4'd0 || ae8 !== 1'b1 || ov8 !== 1'b0) begin
            fails++; $display("FAIL basic_drain got count=%0d ae=%b v=%b exp 0 1 0", oc8, ae8, ov8);
        end
    endtask

    task automatic test_full_and_wrap();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) cycle(1'b1, W'(k), 1'b0, 1'b0);
        tests++;
        if (oc5 !== 3'd6 || rdy5 !== 1'b0) begin
            fails++; $display("FAIL full_state got count=%0d rdy=%b exp 6 0", oc5, rdy5);
        end
        cycle(1'b1, 8'h07, 1'b1, 1'b0);
        tests++;
        if (oc5 !== 3'd5) begin
            fails++; $display("FAIL full_refuse got count=%0d exp 5", oc5);
        end
        for (int k = 0; k < 20; k++) cycle(1'b1, W'($urandom), 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        tests++;
        if (oc5 !== 3'd0 || oc8 !== 4'd0) begin
            fails++; $display("FAIL wrap_drain got %0d/%0d exp 0/0", oc5, oc8);
        end
    endtask

    task automatic test_flags();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, W'(8'h80 + k), 1'b0, 1'b0);
            tests++;
            if (af8 !== (k >= 6) || ae8 !== (k <= 1) || oc8 !== 4'(k)) begin
                fails++; $display("FAIL flags_up[%0d] got af=%b ae=%b count=%0d", k, af8, ae8, oc8);
            end
        end
        for (int k = 7; k >= 0; k--) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            tests++;
            if (af8 !== (k >= 6) || ae8 !== (k <= 1) || oc8 !== 4'(k)) begin
                fails++; $display("FAIL flags_down[%0d] got af=%b ae=%b count=%0d", k, af8, ae8, oc8);
            end
        end
    endtask

    task automatic test_flush();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) cycle(1'b1, W'(8'h40 + k), 1'b0, 1'b0);
        tests++;
        if (oc8 !== 4'd4) begin
            fails++; $display("FAIL flush_pre got count=%0d exp 4", oc8);
        end
        cycle(1'b1, 8'hEE, 1'b1, 1'b1);
        tests++;
        if (oc8 !== 4'd0 || ov8 !== 1'b0 || oc5 !== 3'd0) begin
            fails++; $display("FAIL flush_clear got count=%0d v=%b exp 0 0", oc8, ov8);
        end
        cycle(1'b1, 8'h51, 1'b0, 1'b0);
        cycle(1'b1, 8'h52, 1'b0, 1'b0);
        tests++;
        if (od8 !== 8'h51) begin
            fails++; $display("FAIL flush_after got %h exp 51", od8);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        tests++;
        if (od8 !== 8'h52) begin
            fails++; $display("FAIL flush_after2 got %h exp 52", od8);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) cycle(1'b1, W'(8'h60 + k), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (ov8 !== 1'b0 || oc8 !== 4'd0 || ov5 !== 1'b0 || oc5 !== 3'd0 || od8 !== 8'h00) begin
            fails++; $display("FAIL async_reset got v=%b count=%0d d=%h exp 0 0 00", ov8, oc8, od8);
        end
        mq[0].delete(); mq[1].delete();
        #1 rst_n = 1'b1;
        @(negedge clk);
        cycle(1'b1, 8'hAB, 1'b0, 1'b0);
        tests++;
        if (ov8 !== 1'b1 || od8 !== 8'hAB) begin
            fails++; $display("FAIL post_reset_push got v=%b d=%h exp 1 ab", ov8, od8);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_bypass();
        logic expect_byp;
`ifdef PARAM_SYNC_FIFO_BYPASS_EN
        expect_byp = 1'b1;
`else
        expect_byp = 1'b0;
`endif
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        in_valid = 1'b1; in_data = 8'h5A; in_ready = 1'b1;
        #1;
        tests++;
        if (ov8 !== expect_byp || (expect_byp && od8 !== 8'h5A)) begin
            fails++; $display("FAIL bypass_same_cycle got v=%b d=%h exp v=%b", ov8, od8, expect_byp);
        end
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        tests++;
        if (oc8 !== (expect_byp ? 4'd0 : 4'd1) || ov8 !== !expect_byp) begin
            fails++; $display("FAIL bypass_after got count=%0d v=%b", oc8, ov8);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        tests++;
        if (oc8 !== 4'd1 || od8 !== 8'h3C) begin
            fails++; $display("FAIL bypass_stall got count=%0d d=%h exp 1 3c", oc8, od8);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic v, r, f;
            v = ($urandom_range(0, 3) != 0);
            r = (k < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 39) == 0);
            cycle(v, W'($urandom), r, f);
        end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_full_and_wrap();
        test_flags();
        test_flush();
        test_async_reset();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
